// File: rtl/serial_bus_slave.sv
// Serial-bus slave: receives a 14-cycle address/data/burst frame, then performs
// single or burst byte writes/reads on a local 2^MEM_AW-byte memory.
module serial_bus_slave #(
   parameter logic [1:0] SLAVE_ID = 2'd0,
   parameter int         MEM_AW   = 12
) (
   input  logic clock,
   input  logic reset_n,
   input  logic valid_s,
   input  logic write_en_slave,
   input  logic addr_tx,
   input  logic data_tx,
   input  logic burst_mode,
   output logic data_rx,
   output logic slave_valid,
   output logic slave_ready,
   output logic slave_busy
);

   // state    | meaning
   // IDLE     | waiting for valid_s to open a frame
   // RX_FRAME | frame cycles 1..14: shifting address, data and burst code
   // MEM_WR   | write latched byte, count the beat
   // MEM_RD   | read byte at local address into the transmit shifter
   // TX_VALID | one-cycle slave_valid ahead of a read beat
   // TX_DATA  | eight cycles of read data on data_rx, MSB first
   // BW_REQ   | slave_ready pulse, wait for master to start the next write beat
   // BW_RX    | eight cycles of write data on data_tx, MSB first
   typedef enum logic [2:0] {
      IDLE, RX_FRAME, MEM_WR, MEM_RD, TX_VALID, TX_DATA, BW_REQ, BW_RX
   } state_t;

   localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_nxt;
   logic [3:0]        r_cnt;
   logic [12:0]       r_addr;
   logic [MEM_AW-1:0] r_laddr;
   logic [7:0]        r_data;
   logic [1:0]        r_burst;
   logic [9:0]        r_beat_cnt;
   logic [9:0]        r_beats;
   logic [7:0]        r_shift;
   logic              r_we;
   logic              r_first;
   logic [7:0]        r_mem [0:(1<<MEM_AW)-1];

   logic [13:0]       w_addr_sh;
   logic [7:0]        w_data_sh;
   logic [2:0]        w_burst_sh;
   logic [9:0]        w_beats_inc;
   logic              w_last_bit;

   assign w_addr_sh   = {r_addr, addr_tx};
   assign w_data_sh   = {r_data[6:0], data_tx};
   assign w_burst_sh  = {r_burst, burst_mode};
   assign w_beats_inc = r_beats + 10'd1;
   assign w_last_bit  = (r_cnt == 4'd7);

   function automatic logic [9:0] beats_of(input logic [2:0] code);
      if (code == 3'd0) return 10'd1;
      else              return 10'd8 << (code - 3'd1);
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      slave_valid = 1'b0;
      slave_ready = 1'b0;
      data_rx     = 1'b0;
      slave_busy  = (r_state != IDLE);
      case (r_state)
         IDLE:     if (valid_s) w_state_nxt = RX_FRAME;
         RX_FRAME: begin
            if (!valid_s)                        w_state_nxt = IDLE;
            else if (r_cnt == 4'd14) begin
               if (w_addr_sh[13:12] != SLAVE_ID) w_state_nxt = IDLE;
               else if (r_we)                    w_state_nxt = MEM_WR;
               else                              w_state_nxt = MEM_RD;
            end
         end
         MEM_WR:   w_state_nxt = (w_beats_inc == r_beat_cnt) ? IDLE : BW_REQ;
         BW_REQ: begin
            slave_ready = r_first;
            if (valid_s) w_state_nxt = BW_RX;
         end
         BW_RX: begin
            if (!valid_s)       w_state_nxt = IDLE;
            else if (w_last_bit) w_state_nxt = MEM_WR;
         end
         MEM_RD:   w_state_nxt = TX_VALID;
         TX_VALID: begin
            slave_valid = 1'b1;
            w_state_nxt = TX_DATA;
         end
         TX_DATA: begin
            data_rx = r_shift[7];
            if (w_last_bit)
               w_state_nxt = (w_beats_inc == r_beat_cnt) ? IDLE : MEM_RD;
         end
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt      <= 4'd0;
         r_addr     <= 13'd0;
         r_laddr    <= '0;
         r_data     <= 8'd0;
         r_burst    <= 2'd0;
         r_beat_cnt <= 10'd0;
         r_beats    <= 10'd0;
         r_shift    <= 8'd0;
         r_we       <= 1'b0;
         r_first    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (valid_s) begin
                  r_we    <= write_en_slave;
                  r_cnt   <= 4'd1;
                  r_beats <= 10'd0;
               end
            end
            RX_FRAME: begin
               if (valid_s) begin
                  r_addr <= w_addr_sh[12:0];
                  if (r_cnt >= 4'd7)  r_data  <= w_data_sh;
                  if (r_cnt >= 4'd12) r_burst <= w_burst_sh[1:0];
                  if (r_cnt == 4'd14) begin
                     r_laddr    <= w_addr_sh[MEM_AW-1:0];
                     r_beat_cnt <= beats_of(w_burst_sh);
                     r_cnt      <= 4'd0;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
            end
            MEM_WR: begin
               r_beats <= w_beats_inc;
               r_first <= 1'b1;
            end
            BW_REQ: begin
               if (r_first) begin
                  r_laddr <= r_laddr + ADDR_ONE;
                  r_first <= 1'b0;
               end
               r_cnt <= 4'd0;
            end
            BW_RX: begin
               r_data <= w_data_sh;
               r_cnt  <= w_last_bit ? 4'd0 : r_cnt + 4'd1;
            end
            MEM_RD: begin
               r_shift <= r_mem[r_laddr];
               r_cnt   <= 4'd0;
            end
            TX_DATA: begin
               r_shift <= {r_shift[6:0], 1'b0};
               if (w_last_bit) begin
                  r_cnt   <= 4'd0;
                  r_beats <= w_beats_inc;
                  r_laddr <= r_laddr + ADDR_ONE;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Memory has no reset: contents survive a reset pulse.
   always_ff @(posedge clock) begin
      if (r_state == MEM_WR) r_mem[r_laddr] <= r_data;
   end

endmodule
